mon_tx_fifo: RTL and testbench

Capture buffer that sits directly upstream of the monitor's UART transmitter. It accepts 18-bit bus-monitor event words, one per cycle, from the S1D13700 bus snooper and stores them in a FIFO. It then presents them one at a time on the transmitter's req/ack handshake, bridging single-cycle capture bursts and the much slower 3-byte serial frames. When the FIFO overflows, lost events are counted and can be reported in-band.

---
 rtl/mon_pkg.sv | 13 +
 rtl/mon_tx_fifo_if.sv | 30 +++
 rtl/mon_fifo_ram.sv | 23 ++
 rtl/mon_tx_fifo.sv | 111 +++++++++++
 tb/tb_mon_tx_fifo.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mon_pkg.sv
// Shared event-type codes and constants for the bus-monitor transmit path.
// The drop counter is only built when MON_TX_DROP_CNT_EN is defined.
package mon_pkg;

  localparam logic [1:0]  MON_T_CMDW   = 2'b00;
  localparam logic [1:0]  MON_T_DATW   = 2'b01;
  localparam logic [1:0]  MON_T_DATR   = 2'b10;
  localparam logic [1:0]  MON_T_MARK   = 2'b11;
  localparam logic [15:0] MON_DROP_SAT = 16'hFFFF;

  localparam int MON_EVT_W = 18;

endpackage

// File: rtl/mon_tx_fifo_if.sv
// Capture-side and transmitter-side signals of mon_tx_fifo.
// Optional drop-marker feature of the block is selected by MON_TX_DROP_CNT_EN.
interface mon_tx_fifo_if #(
  parameter int ADDR_W = 4
);

  // Handshakes: cap_vld has no back-pressure, a word is taken or dropped in
  // its cycle. A transfer happens in every cycle where uart_req & uart_ack;
  // uart_req/uart_dat depend on state only and hold until that cycle.
  logic              cap_vld;
  logic [17:0]       cap_dat;
  logic              uart_req;
  logic              uart_ack;
  logic [17:0]       uart_dat;
  logic [ADDR_W:0]   fifo_cnt;
  logic              fifo_full;
  logic              ovf;
  logic              ovf_clr;

  modport master (
    output cap_vld, cap_dat, uart_ack, ovf_clr,
    input  uart_req, uart_dat, fifo_cnt, fifo_full, ovf
  );

  modport slave (
    input  cap_vld, cap_dat, uart_ack, ovf_clr,
    output uart_req, uart_dat, fifo_cnt, fifo_full, ovf
  );

endinterface

// File: rtl/mon_fifo_ram.sv
// Storage array for mon_tx_fifo: one synchronous write port, one
// combinational read port. Contents are intentionally not reset.
module mon_fifo_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdat,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdat
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdat;
  end

  assign rdat = mem_q[raddr];

endmodule

// File: rtl/mon_tx_fifo.sv
// Capture FIFO feeding the monitor UART transmitter, with sticky overflow.
// Define MON_TX_DROP_CNT_EN to count dropped words and report them in-band.
module mon_tx_fifo
  import mon_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst_x,
  mon_tx_fifo_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 req;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 slot_free;
  logic [MON_EVT_W-1:0] wr_dat;
  logic [MON_EVT_W-1:0] rd_dat;

`ifdef MON_TX_DROP_CNT_EN
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 mark;
`endif

  assign req  = (cnt_q != '0);
  assign full = (cnt_q == FULL_CNT);
  assign pop  = req & bus.uart_ack;

  always_comb begin
    slot_free = ~full | pop;
    push      = bus.cap_vld & slot_free;
    drop      = bus.cap_vld & ~slot_free;
    wr_dat    = bus.cap_dat;
`ifdef MON_TX_DROP_CNT_EN
    mark       = (drop_cnt_q != 16'd0) & slot_free;
    drop_cnt_d = drop_cnt_q;
    if (mark) begin
      // Marker takes the free slot; a capture in this cycle is lost and
      // starts the next count.
      push       = 1'b1;
      drop       = bus.cap_vld;
      wr_dat     = {MON_T_MARK, drop_cnt_q};
      drop_cnt_d = {15'd0, bus.cap_vld};
    end else if (drop && (drop_cnt_q != MON_DROP_SAT)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
`endif

    wr_ptr_d = push ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + ADDR_W'(1)) : rd_ptr_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    // Set has priority over clear.
    ovf_d = drop | (ovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef MON_TX_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) drop_cnt_q <= 16'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end
`endif

  mon_fifo_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (MON_EVT_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdat  (wr_dat),
    .raddr (rd_ptr_q),
    .rdat  (rd_dat)
  );

  assign bus.uart_req  = req;
  assign bus.uart_dat  = req ? rd_dat : '0;
  assign bus.fifo_cnt  = cnt_q;
  assign bus.fifo_full = full;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mon_tx_fifo.sv
// Directed + random bench for mon_tx_fifo against a queue-based model.
// Marker checks are compiled in when MON_TX_DROP_CNT_EN is defined.
module tb_mon_tx_fifo;

  logic clk;
  logic rst_x;
  logic ack_en;

  int n_vec;
  int n_err;

  logic [17:0] mq[$];
  logic [17:0] obs_q[$];
  logic        m_ovf;
  int          m_dcnt;

  mon_tx_fifo_if #(.ADDR_W(4)) bus ();

  mon_tx_fifo #(.ADDR_W(4)) dut (
    .clk   (clk),
    .rst_x (rst_x),
    .bus   (bus)
  );

  // Transmitter model: acknowledges whenever asked and idle.
  assign bus.uart_ack = bus.uart_req & ack_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("uart_req",  {17'd0, bus.uart_req},  {17'd0, mq.size() != 0});
    chk("uart_dat",  bus.uart_dat,           (mq.size() != 0) ? mq[0] : 18'h0);
    chk("fifo_cnt",  {13'd0, bus.fifo_cnt},  18'(mq.size()));
    chk("fifo_full", {17'd0, bus.fifo_full}, {17'd0, mq.size() == 16});
    chk("ovf",       {17'd0, bus.ovf},       {17'd0, m_ovf});
  endtask

  // Starts and ends at a falling edge; applies one cycle and checks the result.
  task automatic cyc(input logic vld, input logic [17:0] dat, input logic ack, input logic clr);
    bit pop, slot, push, drop;
    logic [17:0] w;
    bus.cap_vld = vld;
    bus.cap_dat = dat;
    bus.ovf_clr = clr;
    ack_en      = ack;
    pop  = (mq.size() != 0) && ack;
    if (pop) obs_q.push_back(bus.uart_dat);
    slot = (mq.size() < 16) || pop;
    w    = dat;
`ifdef MON_TX_DROP_CNT_EN
    if (m_dcnt != 0 && slot) begin
      push   = 1'b1;
      w      = {2'b11, 16'(m_dcnt)};
      drop   = vld;
      m_dcnt = vld ? 1 : 0;
    end else begin
      push = vld && slot;
      drop = vld && !slot;
      if (drop && m_dcnt < 65535) m_dcnt++;
    end
`else
    push = vld && slot;
    drop = vld && !slot;
`endif
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(w);
    m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    @(posedge clk);
    @(negedge clk);
    bus.cap_vld = 1'b0;
    bus.ovf_clr = 1'b0;
    ack_en      = 1'b0;
    chk_model();
  endtask

  function automatic logic [17:0] rnd_word();
    logic [1:0] t;
    t = 2'($urandom_range(0, 2));
    return {t, 16'($urandom)};
  endfunction

  task automatic fill16();
    for (int k = 0; k < 20 && mq.size() < 16; k++) cyc(1'b1, rnd_word(), 1'b0, 1'b0);
  endtask

  task automatic drain();
    obs_q.delete();
    for (int k = 0; k < 48 && mq.size() != 0; k++) cyc(1'b0, 18'h0, 1'b1, 1'b0);
    chk("drain_empty", {17'd0, bus.uart_req}, 18'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_ovf = 1'b0;
    m_dcnt = 0;
    rst_x = 1'b0;
    ack_en = 1'b0;
    bus.cap_vld = 1'b0;
    bus.cap_dat = 18'h0;
    bus.ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_x = 1'b1;
    chk("rst_req",  {17'd0, bus.uart_req},  18'h0);
    chk("rst_dat",  bus.uart_dat,           18'h0);
    chk("rst_cnt",  {13'd0, bus.fifo_cnt},  18'h0);
    chk("rst_full", {17'd0, bus.fifo_full}, 18'h0);
    chk("rst_ovf",  {17'd0, bus.ovf},       18'h0);

    // Single event
    cyc(1'b1, 18'h1_2345, 1'b0, 1'b0);
    chk("single_req", {17'd0, bus.uart_req}, 18'h1);
    chk("single_dat", bus.uart_dat, 18'h1_2345);
    cyc(1'b0, 18'h0, 1'b1, 1'b0);
    chk("single_done_cnt", {13'd0, bus.fifo_cnt}, 18'h0);
    chk("single_obs", obs_q[obs_q.size()-1], 18'h1_2345);

    // Fill across pointer wrap, then overflow
    for (int i = 0; i < 16; i++) cyc(1'b1, {2'b01, 16'(i * 4097)}, 1'b0, 1'b0);
    chk("fill_full", {17'd0, bus.fifo_full}, 18'h1);
    chk("fill_cnt",  {13'd0, bus.fifo_cnt},  18'd16);
    chk("fill_ovf0", {17'd0, bus.ovf},       18'h0);
    cyc(1'b1, 18'h2_BEEF, 1'b0, 1'b0);
    chk("ovf_set", {17'd0, bus.ovf}, 18'h1);
    chk("ovf_cnt", {13'd0, bus.fifo_cnt}, 18'd16);
    drain();
    chk("drain_first", obs_q[0], 18'h1_0000);
    chk("drain_last",  obs_q[15], {2'b01, 16'(15 * 4097)});
`ifdef MON_TX_DROP_CNT_EN
    chk("drain_len", 18'(obs_q.size()), 18'd17);
    chk("drain_mark1", obs_q[16], 18'h3_0001);
`else
    chk("drain_len", 18'(obs_q.size()), 18'd16);
`endif

    // ovf_clr alone
    cyc(1'b0, 18'h0, 1'b0, 1'b1);
    chk("ovf_clr", {17'd0, bus.ovf}, 18'h0);

    // Push + pop when full
    fill16();
    cyc(1'b1, 18'h0_AAAA, 1'b1, 1'b0);
    chk("pp_full_cnt", {13'd0, bus.fifo_cnt}, 18'd16);
    chk("pp_full_ovf", {17'd0, bus.ovf}, 18'h0);
    drain();
    chk("pp_last", obs_q[obs_q.size()-1], 18'h0_AAAA);

    // Clear coincident with drop
    fill16();
    cyc(1'b1, 18'h2_5555, 1'b0, 1'b1);
    chk("clr_vs_drop", {17'd0, bus.ovf}, 18'h1);
    cyc(1'b0, 18'h0, 1'b0, 1'b1);
    chk("clr_after", {17'd0, bus.ovf}, 18'h0);
    drain();

`ifdef MON_TX_DROP_CNT_EN
    fill16();
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_word(), 1'b0, 1'b0);
    cyc(1'b0, 18'h0, 1'b1, 1'b0);
    chk("mark_cnt", {13'd0, bus.fifo_cnt}, 18'd16);
    drain();
    chk("mark3", obs_q[obs_q.size()-1], 18'h3_0003);

    fill16();
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_word(), 1'b0, 1'b0);
    cyc(1'b1, 18'h1_0F0F, 1'b1, 1'b0);
    chk("mark_vld_cnt", {13'd0, bus.fifo_cnt}, 18'd16);
    drain();
    chk("mark3b", obs_q[obs_q.size()-2], 18'h3_0003);
    chk("mark1b", obs_q[obs_q.size()-1], 18'h3_0001);
    cyc(1'b0, 18'h0, 1'b0, 1'b1);
`endif

    // Reset mid-burst
    for (int i = 0; i < 5; i++) cyc(1'b1, rnd_word(), 1'b0, 1'b0);
    chk("pre_rst_cnt", {13'd0, bus.fifo_cnt}, 18'd5);
    #2 rst_x = 1'b0;
    #1;
    chk("arst_req", {17'd0, bus.uart_req}, 18'h0);
    chk("arst_dat", bus.uart_dat, 18'h0);
    chk("arst_cnt", {13'd0, bus.fifo_cnt}, 18'h0);
    mq.delete();
    m_ovf = 1'b0;
    m_dcnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_x = 1'b1;
    cyc(1'b1, 18'h0_1111, 1'b0, 1'b0);
    chk("post_rst_dat", bus.uart_dat, 18'h0_1111);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), rnd_word(),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
